// File: rtl/pixie_dma_front_end_gen.sv
// pixie_dma_front_end_gen
// Parametrised Pixie-style display front end running in the CDP1802 bus clock
// domain. Generates scan-line and frame timing, the display interrupt, the EF
// flag and DMA-out requests, and captures DMA bytes into a frame-buffer write
// port. A runtime vertical-resolution select maps 1/2/4/8 scan lines onto one
// frame-buffer row.
//
// Optional feature macro: PIXIE_DMA_OVERRUN_EN
//   defined   -> dma_overrun is a sticky flag for DMA overrun/underrun per line
//   undefined -> dma_overrun is tied low and no detection logic is built
//
// Ports:
//   clk          CPU bus clock
//   reset        synchronous, active-high reset
//   clk_enable   one-cycle machine-cycle strobe; all state advances only when high
//   sc[1:0]      CPU state code, 2'b10 marks a DMA cycle
//   disp_on      display-enable request
//   disp_off     display-disable request (wins over disp_on)
//   data[7:0]    CPU data bus
//   res_sel[1:0] scan lines per frame-buffer row = 1 << res_sel
//   dmao         DMA-out request
//   INT          interrupt request (two lines before the active window)
//   efx          EF flag (four lines before and last four lines of the window)
//   frame_start  high for line 0, cycle 0
//   mem_addr     frame-buffer write address
//   mem_data     frame-buffer write data
//   mem_wr_en    frame-buffer write enable
//   dma_overrun  sticky DMA overrun/underrun flag
module pixie_dma_front_end_gen #(
    parameter int unsigned CYCLES_PER_LINE = 14,
    parameter int unsigned LINES_PER_FRAME = 262,
    parameter int unsigned ACTIVE_FIRST    = 80,
    parameter int unsigned ACTIVE_LINES    = 128,
    parameter int unsigned BYTES_PER_LINE  = 8,
    parameter int unsigned DMA_START       = 2,
    parameter int unsigned ADDR_W          = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_enable,
    input  logic [1:0]        sc,
    input  logic              disp_on,
    input  logic              disp_off,
    input  logic [7:0]        data,
    input  logic [1:0]        res_sel,
    output logic              dmao,
    output logic              INT,
    output logic              efx,
    output logic              frame_start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_wr_en,
    output logic              dma_overrun
);

    localparam int unsigned CYC_W   = (CYCLES_PER_LINE > 1) ? $clog2(CYCLES_PER_LINE) : 1;
    localparam int unsigned LINE_W  = (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1;
    localparam int unsigned COL_W   = $clog2(BYTES_PER_LINE + 1);
    localparam int unsigned ACT_END = ACTIVE_FIRST + ACTIVE_LINES;
    localparam int unsigned DMA_END = DMA_START + BYTES_PER_LINE;

    localparam logic [CYC_W-1:0]  CYC_LAST    = CYC_W'(CYCLES_PER_LINE - 1);
    localparam logic [LINE_W-1:0] LINE_LAST   = LINE_W'(LINES_PER_FRAME - 1);
    localparam logic [LINE_W-1:0] ACT_FIRST_L = LINE_W'(ACTIVE_FIRST);
    localparam logic [ADDR_W-1:0] BPL_A       = ADDR_W'(BYTES_PER_LINE);

    logic [CYC_W-1:0]  cyc;
    logic [LINE_W-1:0] line;
    logic [COL_W-1:0]  col;
    logic              disp_req;
    logic              disp_act;
    logic [1:0]        res_lat;

    logic [31:0]       cyc32_c;
    logic [31:0]       line32_c;
    logic              line_end_c;
    logic              frame_end_c;
    logic              frame_pos_c;
    logic              active_c;
    logic              int_c;
    logic              efx_c;
    logic              dma_win_c;
    logic              sample_c;
    logic              write_c;
    logic [LINE_W-1:0] aline_c;
    logic [LINE_W-1:0] row_c;
    logic [ADDR_W-1:0] addr_c;

    // Decode of the current counter position into timing and capture qualifiers
    always_comb begin
        cyc32_c     = 32'(cyc);
        line32_c    = 32'(line);
        line_end_c  = (cyc == CYC_LAST);
        frame_end_c = (line == LINE_LAST);
        frame_pos_c = (cyc == '0) && (line == '0);
        active_c    = (line32_c >= ACTIVE_FIRST) && (line32_c < ACT_END);
        int_c       = disp_act && ((line32_c == ACTIVE_FIRST - 2) || (line32_c == ACTIVE_FIRST - 1));
        efx_c       = ((line32_c >= ACTIVE_FIRST - 4) && (line32_c < ACTIVE_FIRST)) ||
                      ((line32_c >= ACT_END - 4) && (line32_c < ACT_END));
        dma_win_c   = (cyc32_c >= DMA_START) && (cyc32_c < DMA_END);
        sample_c    = (sc == 2'b10) && disp_act && active_c;
        write_c     = sample_c && (32'(col) < BYTES_PER_LINE);
        aline_c     = line - ACT_FIRST_L;
        // Several scan lines share a row; they rewrite the same addresses
        row_c       = aline_c >> res_lat;
        addr_c      = ADDR_W'(row_c) * BPL_A + ADDR_W'(col);
    end

    // Counters, display enable and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc         <= '0;
            line        <= '0;
            col         <= '0;
            disp_req    <= 1'b0;
            disp_act    <= 1'b0;
            res_lat     <= 2'b00;
            dmao        <= 1'b0;
            INT         <= 1'b0;
            efx         <= 1'b0;
            frame_start <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_addr    <= '0;
            mem_data    <= 8'h00;
        end else if (clk_enable) begin
            if (line_end_c) begin
                cyc  <= '0;
                line <= frame_end_c ? '0 : line + 1'b1;
                col  <= '0;
            end else begin
                cyc <= cyc + 1'b1;
                if (write_c) begin
                    col <= col + 1'b1;
                end
            end

            if (disp_off) begin
                disp_req <= 1'b0;
            end else if (disp_on) begin
                disp_req <= 1'b1;
            end

            // Display enable and resolution only change on frame boundaries
            if (frame_pos_c) begin
                disp_act <= disp_req;
                res_lat  <= res_sel;
            end

            dmao        <= disp_act && active_c && dma_win_c;
            INT         <= int_c;
            efx         <= efx_c;
            frame_start <= frame_pos_c;
            mem_wr_en   <= write_c;
            if (write_c) begin
                mem_addr <= addr_c;
                mem_data <= data;
            end
        end
    end

`ifdef PIXIE_DMA_OVERRUN_EN
    logic [31:0] col_next32_c;
    logic        underrun_c;

    // A line that started DMA but ended short of a full row is an underrun
    always_comb begin
        col_next32_c = 32'(col) + 32'(write_c);
        underrun_c   = line_end_c && (col_next32_c != 32'd0) && (col_next32_c < BYTES_PER_LINE);
    end

    // Sticky flag; a new detection in the same cycle wins over the disp_on clear
    always_ff @(posedge clk) begin
        if (reset) begin
            dma_overrun <= 1'b0;
        end else if (clk_enable) begin
            if ((sample_c && !write_c) || underrun_c) begin
                dma_overrun <= 1'b1;
            end else if (disp_on) begin
                dma_overrun <= 1'b0;
            end
        end
    end
`else
    assign dma_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_pixie_dma_front_end_gen.sv
// Directed bench for pixie_dma_front_end_gen with default geometry
// (14 cycles/line, 262 lines/frame, active lines 80..207, 8 bytes/line).
module tb_pixie_dma_front_end_gen;

    localparam int unsigned ADDR_W = 10;
`ifdef PIXIE_DMA_OVERRUN_EN
    localparam logic OVR = 1'b1;
`else
    localparam logic OVR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              clk_enable;
    logic [1:0]        sc;
    logic              disp_on;
    logic              disp_off;
    logic [7:0]        data;
    logic [1:0]        res_sel;
    logic              dmao;
    logic              INT;
    logic              efx;
    logic              frame_start;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic              mem_wr_en;
    logic              dma_overrun;

    int errors = 0;
    int checks = 0;

    // Position (line, cycle) that the next enabled edge will process
    int   tl = 0;
    int   tc = 0;
    logic exp_req = 1'b0;
    logic exp_act = 1'b0;

    int mis_fs, mis_int, mis_efx, mis_dmao;
    int n_fs, n_int, n_efx, n_dmao, n_wr;

    always #5 clk = ~clk;

    pixie_dma_front_end_gen dut (
        .clk         (clk),
        .reset       (reset),
        .clk_enable  (clk_enable),
        .sc          (sc),
        .disp_on     (disp_on),
        .disp_off    (disp_off),
        .data        (data),
        .res_sel     (res_sel),
        .dmao        (dmao),
        .INT         (INT),
        .efx         (efx),
        .frame_start (frame_start),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_wr_en   (mem_wr_en),
        .dma_overrun (dma_overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic clr();
        mis_fs = 0; mis_int = 0; mis_efx = 0; mis_dmao = 0;
        n_fs = 0; n_int = 0; n_efx = 0; n_dmao = 0; n_wr = 0;
    endtask

    // One enabled machine cycle; timing outputs compared against the line/cycle table
    task automatic tick(input logic [1:0] sc_v, input logic [7:0] d_v);
        logic e_fs, e_int, e_efx, e_dmao;
        e_fs   = (tl == 0) && (tc == 0);
        e_int  = exp_act && ((tl == 78) || (tl == 79));
        e_efx  = ((tl >= 76) && (tl <= 79)) || ((tl >= 204) && (tl <= 207));
        e_dmao = exp_act && (tl >= 80) && (tl <= 207) && (tc >= 2) && (tc <= 9);
        if (e_fs) exp_act = exp_req;
        if (disp_off) exp_req = 1'b0;
        else if (disp_on) exp_req = 1'b1;
        sc = sc_v;
        data = d_v;
        clk_enable = 1'b1;
        @(posedge clk);
        #1;
        disp_on = 1'b0;
        disp_off = 1'b0;
        sc = 2'b00;
        if (frame_start !== e_fs) mis_fs++;
        if (INT !== e_int) mis_int++;
        if (efx !== e_efx) mis_efx++;
        if (dmao !== e_dmao) mis_dmao++;
        if (frame_start === 1'b1) n_fs++;
        if (INT === 1'b1) n_int++;
        if (efx === 1'b1) n_efx++;
        if (dmao === 1'b1) n_dmao++;
        if (mem_wr_en === 1'b1) n_wr++;
        if (tc == 13) begin
            tc = 0;
            tl = (tl == 261) ? 0 : tl + 1;
        end else begin
            tc++;
        end
    endtask

    task automatic run_to(input int l, input int c);
        while (!((tl == l) && (tc == c))) tick(2'b00, 8'h00);
    endtask

    task automatic run_frame();
        tick(2'b00, 8'h00);
        run_to(0, 0);
    endtask

    task automatic chk_sweep();
        chk("sweep_frame_start", 32'(mis_fs), 0);
        chk("sweep_int", 32'(mis_int), 0);
        chk("sweep_efx", 32'(mis_efx), 0);
        chk("sweep_dmao", 32'(mis_dmao), 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_dmao"}, 32'(dmao), 0);
        chk({tag, "_int"}, 32'(INT), 0);
        chk({tag, "_efx"}, 32'(efx), 0);
        chk({tag, "_frame_start"}, 32'(frame_start), 0);
        chk({tag, "_mem_wr_en"}, 32'(mem_wr_en), 0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
        chk({tag, "_mem_data"}, 32'(mem_data), 0);
        chk({tag, "_dma_overrun"}, 32'(dma_overrun), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired before the end of the run");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; clk_enable = 1'b1; sc = 2'b00; disp_on = 1'b0;
        disp_off = 1'b0; data = 8'h00; res_sel = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        reset = 1'b0;

        // Frame 1: display off, only efx toggles
        clr();
        run_frame();
        chk_sweep();
        chk("f1_frame_start_count", 32'(n_fs), 1);
        chk("f1_efx_count", 32'(n_efx), 112);
        chk("f1_int_count", 32'(n_int), 0);
        chk("f1_dmao_count", 32'(n_dmao), 0);
        chk("f1_wr_count", 32'(n_wr), 0);

        // Frame 2: disp_on mid-frame must not start DMA before the frame boundary
        clr();
        run_to(100, 0);
        disp_on = 1'b1;
        tick(2'b00, 8'h00);
        run_to(0, 0);
        chk_sweep();
        chk("f2_dmao_count", 32'(n_dmao), 0);
        chk("f2_int_count", 32'(n_int), 0);

        // Frame 3: display on, res_sel=0
        clr();
        run_to(80, 2);
        chk("f3_int_before_active", 32'(n_int), 28);
        for (int i = 0; i < 8; i++) begin
            tick(2'b10, 8'(i));
            chk("l80_wr_en", 32'(mem_wr_en), 1);
            chk("l80_addr", 32'(mem_addr), 32'(i));
            chk("l80_data", 32'(mem_data), 32'(i));
            if (i == 3) begin
                clk_enable = 1'b0;
                sc = 2'b10;
                data = 8'hFF;
                repeat (2) @(posedge clk);
                #1;
                chk("hold_wr_en", 32'(mem_wr_en), 1);
                chk("hold_addr", 32'(mem_addr), 3);
                chk("hold_data", 32'(mem_data), 3);
                chk("hold_dmao", 32'(dmao), 1);
            end
        end
        tick(2'b00, 8'h00);
        chk("l80_end_wr_en", 32'(mem_wr_en), 0);
        chk("l80_end_addr_hold", 32'(mem_addr), 7);
        chk("l80_end_data_hold", 32'(mem_data), 7);
        chk("l80_no_overrun", 32'(dma_overrun), 0);

        // res_sel changes mid-frame are ignored until the next frame
        res_sel = 2'b10;
        run_to(81, 2);
        tick(2'b10, 8'hC3);
        chk("l81_addr", 32'(mem_addr), 8);
        chk("l81_data", 32'(mem_data), 32'h00C3);
        run_to(82, 0);
        chk("l81_underrun", 32'(dma_overrun), 32'(OVR));
        disp_on = 1'b1;
        tick(2'b00, 8'h00);
        chk("l82_clear", 32'(dma_overrun), 0);
        run_to(0, 0);
        chk_sweep();
        chk("f3_dmao_count", 32'(n_dmao), 1024);
        chk("f3_int_count", 32'(n_int), 28);
        chk("f3_efx_count", 32'(n_efx), 112);
        chk("f3_wr_count", 32'(n_wr), 9);

        // Frame 4: res_sel=2, four scan lines per row
        clr();
        run_to(84, 2);
        tick(2'b10, 8'h55);
        chk("l84_addr", 32'(mem_addr), 8);
        chk("l84_data", 32'(mem_data), 32'h0055);
        run_to(85, 0);
        chk("l84_underrun", 32'(dma_overrun), 32'(OVR));
        disp_on = 1'b1;
        tick(2'b00, 8'h00);
        chk("l85_clear", 32'(dma_overrun), 0);
        run_to(87, 2);
        for (int i = 0; i < 8; i++) begin
            tick(2'b10, 8'(8'hA0 + i));
            chk("l87_wr_en", 32'(mem_wr_en), 1);
            chk("l87_addr", 32'(mem_addr), 32'(8 + i));
            chk("l87_data", 32'(mem_data), 32'(8'hA0 + i));
        end
        run_to(88, 0);
        chk("l87_no_overrun", 32'(dma_overrun), 0);
        run_to(88, 2);
        for (int i = 0; i < 9; i++) begin
            tick(2'b10, 8'(8'h10 + i));
            if (i < 8) begin
                chk("l88_addr", 32'(mem_addr), 32'(16 + i));
                chk("l88_wr_en", 32'(mem_wr_en), 1);
            end
        end
        chk("l88_ninth_wr_en", 32'(mem_wr_en), 0);
        chk("l88_ninth_addr_hold", 32'(mem_addr), 23);
        chk("l88_ninth_data_hold", 32'(mem_data), 32'h0017);
        chk("l88_overrun", 32'(dma_overrun), 32'(OVR));
        disp_on = 1'b1;
        tick(2'b00, 8'h00);
        chk("l88_clear", 32'(dma_overrun), 0);

        // Reset in the middle of an active line with a write pending
        run_to(100, 4);
        tick(2'b10, 8'h77);
        chk("l100_addr", 32'(mem_addr), 40);
        chk("l100_wr_en", 32'(mem_wr_en), 1);
        chk("l100_dmao", 32'(dmao), 1);
        chk_sweep();
        chk("f4_int_count", 32'(n_int), 28);
        chk("f4_wr_count", 32'(n_wr), 18);
        reset = 1'b1;
        sc = 2'b10;
        data = 8'h99;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sc = 2'b00;
        tl = 0; tc = 0; exp_act = 1'b0; exp_req = 1'b0;
        chk_zero("midreset");

        // disp_on then disp_on+disp_off together: display stays off next frame
        clr();
        run_to(10, 0);
        disp_on = 1'b1;
        tick(2'b00, 8'h00);
        run_to(50, 0);
        disp_on = 1'b1;
        disp_off = 1'b1;
        tick(2'b00, 8'h00);
        run_to(0, 0);
        run_frame();
        chk_sweep();
        chk("both_dmao_count", 32'(n_dmao), 0);
        chk("both_int_count", 32'(n_int), 0);
        chk("both_fs_count", 32'(n_fs), 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pixie_dma_front_end_gen.md
# pixie_dma_front_end_gen

Parametrised successor to the Pixie display front end, in the CDP1802 bus clock domain. Generates line/frame timing, interrupt, EF flag and DMA-out requests, and captures DMA bytes into the frame-buffer write port. Generalises geometry (bytes per line, lines per frame, active window) and adds a runtime vertical-resolution select that maps 1, 2, 4 or 8 scan lines onto one frame-buffer row.

## Interface
Parameters:
- CYCLES_PER_LINE, 14, machine cycles per scan line (≥ DMA_START+BYTES_PER_LINE)
- LINES_PER_FRAME, 262, scan lines per frame
- ACTIVE_FIRST, 80, first active scan line (≥ 4)
- ACTIVE_LINES, 128, active scan lines, multiple of 8
- BYTES_PER_LINE, 8, DMA bytes per active line
- DMA_START, 2, cycle index of the first dmao cycle in a line
- ADDR_W, 10, frame-buffer address width

Ports:
- clk  in  1  CPU bus clock
- reset  in  1  synchronous, active-high
- clk_enable  in  1  one-cycle machine-cycle strobe; all state advances only when high
- sc  in  2  CPU state code; 2'b10 = DMA cycle
- disp_on  in  1  display-enable request
- disp_off  in  1  display-disable request
- data  in  8  CPU data bus
- res_sel  in  2  scan lines per row = 1 << res_sel
- dmao  out  1  DMA-out request
- INT  out  1  interrupt request
- efx  out  1  EF flag
- frame_start  out  1  high for line 0, cycle 0
- mem_addr  out  ADDR_W  frame-buffer write address
- mem_data  out  8  frame-buffer write data
- mem_wr_en  out  1  frame-buffer write enable
- dma_overrun  out  1  sticky overrun flag (see Configuration)

## Operation
- Counters: cyc 0..CYCLES_PER_LINE-1, line 0..LINES_PER_FRAME-1; cyc increments on clk_enable, wraps to 0 and increments line; line wraps to 0 after LINES_PER_FRAME-1.
- disp_req flag: disp_on sets, disp_off clears; both high in the same enabled cycle → cleared. disp_act is loaded from disp_req only at line 0, cyc 0, so enable and disable take effect at frame boundaries.
- Active line: ACTIVE_FIRST ≤ line < ACTIVE_FIRST+ACTIVE_LINES; aline = line − ACTIVE_FIRST.
- INT = disp_act and line ∈ {ACTIVE_FIRST−2, ACTIVE_FIRST−1}.
- efx = line ∈ [ACTIVE_FIRST−4, ACTIVE_FIRST−1] or the last 4 active lines, independent of disp_act.
- dmao = disp_act and active line and DMA_START ≤ cyc < DMA_START+BYTES_PER_LINE.
- Capture: an enabled cycle with sc=2'b10, disp_act and active line is a DMA sample.
  - If col < BYTES_PER_LINE: register data and addr = (aline >> res_sel)·BYTES_PER_LINE + col, truncated to ADDR_W; assert mem_wr_en; increment col.
  - Otherwise the sample is an overrun: no write.
- col resets to 0 at cyc 0 of every line.
- Repeated lines in a row rewrite the same addresses; the last write wins.
- res_sel is sampled at line 0, cyc 0 and held for the frame.

## Timing
- All outputs are registered and update only on clk_enable edges. Each value holds until the next enabled edge, which makes it safe for the downstream clk_enable&mem_wr_en qualification.
- Latency: a DMA sample at enabled edge N presents mem_addr, mem_data and mem_wr_en = 1 from edge N until enabled edge N+1. If the next enabled cycle is not a valid sample, mem_wr_en drops to 0; mem_addr and mem_data hold their last values.
- dmao, INT, efx and frame_start reflect the counter state of the same enabled cycle, with one enabled-cycle register delay.
- Reset values: cyc=0, line=0, col=0, disp_req=0, disp_act=0, res_sel latch=0; dmao=0, INT=0, efx=0, frame_start=0, mem_wr_en=0, mem_addr=0, mem_data=0, dma_overrun=0.
- Reset mid-frame aborts the current line. No partial write is emitted after reset.
- clk_enable low: no state change, outputs hold.

## Configuration
- PIXIE_DMA_OVERRUN_EN defined:
  - dma_overrun is set on any overrun sample.
  - It is also set when a line ends with 0 < col < BYTES_PER_LINE (underrun).
  - It is cleared by reset or by disp_on.
- Undefined: dma_overrun is tied 0 and no detection logic is built.

## Test plan
- Reset, then 262×14 enables, no disp_on → efx high exactly on lines 76–79 and 204–207; INT, dmao and mem_wr_en never high.
- disp_on mid-frame → no dmao until next line 0. Then INT high on lines 78–79; dmao high at cyc 2–9 on lines 80–207.
- res_sel=0, DMA bytes 0x00..0x07 with sc=2'b10 on line 80 → writes to addr 0..7 with matching data, mem_wr_en held one enabled period each.
- res_sel=2, line 87 DMA → writes to addr 8..15; lines 84–87 all target row 1.
- disp_on and disp_off asserted together → display stays off next frame. Reset asserted on line 100, cyc 5 → all outputs 0 on the following edge.
- With PIXIE_DMA_OVERRUN_EN: 9 DMA samples in one line → 8 writes, dma_overrun=1. A subsequent disp_on clears it. Without the macro, dma_overrun stays 0.
